// File: rtl/cos_range_reducer.sv
// Folds a signed Q8.8 angle into [0, pi/2] for CosAccel, then strobes cos_start; latency 4+n+START_CYCLES edges (n = 2*pi wraps).
// No backpressure: a request that arrives while busy is dropped, and a start held high counts once.
module cos_range_reducer #(
   parameter int W            = 16,
   parameter int Y_W          = 8,
   parameter int TWO_PI       = 1608,
   parameter int PI           = 804,
   parameter int HALF_PI      = 402,
   parameter int START_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   x_in,
   input  logic [Y_W-1:0] y_in,
   output logic [W-1:0]   x_bus,
   output logic [Y_W-1:0] y_bus,
   output logic           cos_start,
   output logic           neg_out,
   output logic           busy,
   output logic           done
);

   localparam int HW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

   localparam logic [W:0]  TWO_PI_R  = (W+1)'(TWO_PI);
   localparam logic [W:0]  PI_R      = (W+1)'(PI);
   localparam logic [W:0]  HALF_PI_R = (W+1)'(HALF_PI);
   localparam logic [W:0]  ONE_R     = (W+1)'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(START_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ABS   = 3'd1,
      WRAP  = 3'd2,
      FOLD1 = 3'd3,
      FOLD2 = 3'd4,
      ISSUE = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t        state;
   logic          start_q;
   logic          req;
   logic [W-1:0]  x_lat;
   logic [W:0]    r;
   logic [HW-1:0] hold;

   // One extra magnitude bit so that |-32768| survives the ABS step.
   logic [W:0] abs_x;
   logic [W:0] r_minus_two_pi;
   logic [W:0] two_pi_minus_r;
   logic [W:0] pi_minus_r;

   assign req            = start & ~start_q;
   assign abs_x          = x_lat[W-1] ? ({1'b0, ~x_lat} + ONE_R) : {1'b0, x_lat};
   assign r_minus_two_pi = r - TWO_PI_R;
   assign two_pi_minus_r = TWO_PI_R - r;
   assign pi_minus_r     = PI_R - r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         x_lat     <= '0;
         r         <= '0;
         hold      <= '0;
         x_bus     <= '0;
         y_bus     <= '0;
         neg_out   <= 1'b0;
         cos_start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (req) begin
                  x_lat <= x_in;
                  y_bus <= y_in;
                  busy  <= 1'b1;
                  state <= ABS;
               end
            end
            ABS: begin
               r     <= abs_x;
               state <= WRAP;
            end
            WRAP: begin
               if (r >= TWO_PI_R) begin
                  r <= r_minus_two_pi;
               end else begin
                  state <= FOLD1;
               end
            end
            FOLD1: begin
               if (r > PI_R) begin
                  r <= two_pi_minus_r;
               end
               state <= FOLD2;
            end
            FOLD2: begin
               // Past pi/2 the cosine is evaluated on pi - r and negated downstream.
               if (r > HALF_PI_R) begin
                  x_bus   <= W'(pi_minus_r);
                  neg_out <= 1'b1;
               end else begin
                  x_bus   <= W'(r);
                  neg_out <= 1'b0;
               end
               cos_start <= 1'b1;
               hold      <= '0;
               state     <= ISSUE;
            end
            ISSUE: begin
               if (hold == HOLD_LAST) begin
                  cos_start <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  hold <= hold + HW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               cos_start <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
